// File: rtl/cordic_sqrt_norm_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : cordic_sqrt_norm_seq_if
// Brief   : start/operand request and busy/done/result response of the sqrt unit
// Rev     : 1.0
// ============================================================================
interface cordic_sqrt_norm_seq_if #(
  parameter int BW_DIN  = 16,
  parameter int BW_FRAC = 8
);
  logic                          start;
  logic [BW_DIN-1:0]             din;
  logic                          busy;
  logic                          done;
  logic [BW_DIN/2+BW_FRAC-1:0]   dout;

  modport master (output start, din, input busy, done, dout);
  modport slave  (input start, din, output busy, done, dout);
endinterface
`default_nettype wire

// File: rtl/cordic_sqrt_norm_seq.sv
`default_nettype none
// ============================================================================
// Module  : cordic_sqrt_norm_seq
// Brief   : sequential hyperbolic-vectoring CORDIC sqrt with even-shift
//           normalisation, shift-add gain correction, rounding and saturation
// Rev     : 1.0
// ============================================================================
module cordic_sqrt_norm_seq #(
  parameter int BW_DIN   = 16,
  parameter int BW_FRAC  = 8,
  parameter int N_ITER   = 14,
  parameter int BW_GUARD = 4,
  parameter int BW_K     = 18
) (
  input  logic                  clk,
  input  logic                  rstx,
  cordic_sqrt_norm_seq_if.slave bus
);

  localparam int C_HALF    = BW_DIN / 2;
  localparam int C_BW_OUT  = C_HALF + BW_FRAC;
  localparam int C_FR      = BW_DIN + BW_GUARD;
  localparam int C_BW_XY   = BW_DIN + 2 + BW_GUARD;
  localparam int C_BW_ACC  = C_BW_XY + BW_K;
  localparam int C_NSTEP   = N_ITER + ((N_ITER >= 4) ? 1 : 0) + ((N_ITER >= 13) ? 1 : 0);
  localparam int C_CNT_MAX = (C_NSTEP > BW_K) ? C_NSTEP : BW_K;
  localparam int C_BW_CNT  = $clog2(C_CNT_MAX + 1);
  localparam int C_BW_KSH  = $clog2(C_HALF + 1);
  localparam int C_RSH0    = C_FR + BW_K - C_HALF - BW_FRAC - 1;

  localparam logic signed [C_BW_XY-1:0] C_ONE = C_BW_XY'(1) << C_FR;
  localparam logic [C_BW_ACC-1:0]       C_LIM = C_BW_ACC'(1) << C_BW_OUT;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NORM = 3'd1,
    S_ITER = 3'd2,
    S_GAIN = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // Shift sequence 1,2,3,4,4,5,...,13,13,14,...: steps 4 and 14 repeat the previous shift.
  function automatic int step_shift(input int idx);
    return idx + 1 - ((idx >= 4) ? 1 : 0) - ((idx >= 14) ? 1 : 0);
  endfunction

  // 1/(2*Kh) in Q0.BW_K; Kh^2 accumulated exactly in Q2.62, then an integer sqrt and a rounded divide.
  function automatic logic [BW_K-1:0] gain_const();
    logic [63:0] p;
    logic [63:0] root;
    logic [63:0] trial;
    logic [63:0] num;
    logic [63:0] q;
    p = 64'h1 << 62;
    for (int i = 0; i < C_NSTEP; i++) begin
      p = p - (p >> (2 * step_shift(i)));
    end
    root = 64'h0;
    for (int b = 31; b >= 0; b--) begin
      trial = root | (64'h1 << b);
      if (trial * trial <= p) root = trial;
    end
    num = 64'h1 << (BW_K + 30);
    q   = (num + (root >> 1)) / root;
    return q[BW_K-1:0];
  endfunction

  localparam logic [BW_K-1:0] C_GAIN = gain_const();

  state_t                      r_state;
  logic [BW_DIN-1:0]           r_din;
  logic [C_BW_KSH-1:0]         r_k;
  logic                        r_zero;
  logic signed [C_BW_XY-1:0]   r_x;
  logic signed [C_BW_XY-1:0]   r_y;
  logic [C_BW_CNT-1:0]         r_cnt;
  logic [BW_K-1:0]             r_kbits;
  logic [C_BW_ACC-1:0]         r_mcand;
  logic [C_BW_ACC-1:0]         r_acc;
  logic                        r_busy;
  logic                        r_done;
  logic [C_BW_OUT-1:0]         r_dout;

  logic [C_BW_KSH-1:0]         w_k;
  logic [BW_DIN-1:0]           w_m;
  logic signed [C_BW_XY-1:0]   w_x0;
  logic signed [C_BW_XY-1:0]   w_y0;
  logic signed [C_BW_XY-1:0]   w_xs;
  logic signed [C_BW_XY-1:0]   w_ys;
  logic signed [C_BW_XY-1:0]   w_xn;
  logic signed [C_BW_XY-1:0]   w_yn;
  logic [C_BW_ACC-1:0]         w_t;
  logic [C_BW_ACC-1:0]         w_r;
  logic [C_BW_OUT-1:0]         w_res;

  always_comb begin
    w_k = C_BW_KSH'(C_HALF);
    for (int i = 0; i < BW_DIN; i++) begin
      if (r_din[i]) w_k = C_BW_KSH'((BW_DIN - 1 - i) / 2);
    end
    w_m  = r_din << {w_k, 1'b0};
    w_x0 = C_ONE + (C_BW_XY'(w_m) << BW_GUARD);
    w_y0 = (C_BW_XY'(w_m) << BW_GUARD) - C_ONE;

    w_xs = r_x >>> step_shift(int'(r_cnt));
    w_ys = r_y >>> step_shift(int'(r_cnt));
    // Rotate so that y is driven toward zero from whichever side it sits on.
    w_xn = r_y[C_BW_XY-1] ? (r_x + w_ys) : (r_x - w_ys);
    w_yn = r_y[C_BW_XY-1] ? (r_y + w_xs) : (r_y - w_xs);

    // Denormalise by 2^(HALF-k) and keep one extra bit for half-up rounding.
    w_t = r_acc >> (C_RSH0 + int'(r_k));
    w_r = (w_t + C_BW_ACC'(1)) >> 1;
    if (r_zero)           w_res = '0;
    else if (w_r >= C_LIM) w_res = '1;
    else                  w_res = w_r[C_BW_OUT-1:0];
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_state <= S_IDLE;
      r_din   <= '0;
      r_k     <= '0;
      r_zero  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_kbits <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_din   <= bus.din;
        r_busy  <= 1'b1;
        r_state <= S_NORM;
      end else begin
        case (r_state)
          S_NORM: begin
            r_k     <= w_k;
            r_zero  <= (r_din == '0);
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
          S_ITER: begin
            r_x <= w_xn;
            r_y <= w_yn;
            if (r_cnt == C_BW_CNT'(C_NSTEP - 1)) begin
              r_cnt   <= '0;
              r_mcand <= C_BW_ACC'($unsigned(w_xn));
              r_acc   <= '0;
              r_kbits <= C_GAIN;
              r_state <= S_GAIN;
            end else begin
              r_cnt <= r_cnt + C_BW_CNT'(1);
            end
          end
          S_GAIN: begin
            if (r_kbits[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_kbits <= r_kbits >> 1;
            r_cnt   <= r_cnt + C_BW_CNT'(1);
            if (r_cnt == C_BW_CNT'(BW_K - 1)) r_state <= S_OUT;
          end
          S_OUT: begin
            r_dout  <= w_res;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sqrt_norm_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cordic_sqrt_norm_seq
// Brief   : directed/swept bench with a real-valued sqrt reference model
// Rev     : 1.0
// ============================================================================
module tb_cordic_sqrt_norm_seq;
  localparam int BW_DIN   = 16;
  localparam int BW_FRAC  = 8;
  localparam int N_ITER   = 14;
  localparam int BW_GUARD = 4;
  localparam int BW_K     = 18;
  localparam int N_STEP   = N_ITER + ((N_ITER >= 4) ? 1 : 0) + ((N_ITER >= 13) ? 1 : 0);
  localparam int LAT      = 2 + N_STEP + BW_K;
  localparam int OUT_MAX  = (1 << (BW_DIN / 2 + BW_FRAC)) - 1;

  logic clk = 1'b0;
  logic rstx;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_sqrt_norm_seq_if #(.BW_DIN(BW_DIN), .BW_FRAC(BW_FRAC)) bus ();

  cordic_sqrt_norm_seq #(
    .BW_DIN(BW_DIN), .BW_FRAC(BW_FRAC), .N_ITER(N_ITER),
    .BW_GUARD(BW_GUARD), .BW_K(BW_K)
  ) dut (
    .clk(clk),
    .rstx(rstx),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: one outstanding request and the acceptable range of the held result.
  bit          m_pend;
  int          m_age;
  int          m_din;
  bit          m_done;
  int          held_lo;
  int          held_hi;

  function automatic int exact_tab(input int d);
    case (d)
      'h0000:  return 'h0000;
      'h0001:  return 'h0100;
      'h0004:  return 'h0200;
      'h0009:  return 'h0300;
      'h0010:  return 'h0400;
      'h0019:  return 'h0500;
      'h0040:  return 'h0800;
      'h4000:  return 'h8000;
      'hFFFF:  return 'hFFFF;
      default: return -1;
    endcase
  endfunction

  task automatic set_expect(input int d);
    int  ex;
    real e;
    ex = exact_tab(d);
    if (ex >= 0) begin
      held_lo = ex;
      held_hi = ex;
    end else if (d == 2) begin
      held_lo = 'h169;
      held_hi = 'h16B;
    end else begin
      e = $sqrt(real'(d)) * real'(1 << BW_FRAC);
      if (e > real'(OUT_MAX)) e = real'(OUT_MAX);
      held_lo = int'($ceil(e - 1.0));
      held_hi = int'($floor(e + 1.0));
      if (held_lo < 0) held_lo = 0;
      if (held_hi > OUT_MAX) held_hi = OUT_MAX;
    end
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_age   = 0;
    m_din   = 0;
    m_done  = 1'b0;
    held_lo = 0;
    held_hi = 0;
  endtask

  task automatic chk(input string nm, input int got, input int lo, input int hi);
    n_vec++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got 0x%0h, required 0x%0h..0x%0h", nm, cyc, got, lo, hi);
    end
  endtask

  initial begin : compare
    model_reset();
    wait (rstx === 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0, 0);
    chk("reset_done", int'(bus.done), 0, 0);
    chk("reset_dout", int'(bus.dout), 0, 0);
    wait (rstx === 1'b1);
    forever begin
      @(posedge clk or negedge rstx);
      if (rstx === 1'b0) begin
        model_reset();
        #1;
        chk("async_rst_busy", int'(bus.busy), 0, 0);
        chk("async_rst_done", int'(bus.done), 0, 0);
        chk("async_rst_dout", int'(bus.dout), 0, 0);
      end else begin
        m_done = 1'b0;
        if (bus.start) begin
          m_pend = 1'b1;
          m_din  = int'(bus.din);
          m_age  = 0;
        end else if (m_pend) begin
          m_age++;
          if (m_age == LAT) begin
            m_pend = 1'b0;
            m_done = 1'b1;
            set_expect(m_din);
          end
        end
        @(negedge clk);
        chk("busy", int'(bus.busy), int'(m_pend), int'(m_pend));
        chk("done", int'(bus.done), int'(m_done), int'(m_done));
        chk("dout", int'(bus.dout), held_lo, held_hi);
      end
    end
  end

  task automatic run(input int d, input bit now);
    logic [31:0] dv;
    dv = d;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.din   = dv[BW_DIN-1:0];
    @(negedge clk);
    bus.start = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin : driver
    rstx      = 1'b0;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    rstx = 1'b1;

    run('h0000, 1'b0);
    run('h0001, 1'b0);
    run('h0004, 1'b0);
    run('h4000, 1'b0);
    run('hFFFF, 1'b0);
    run('h0002, 1'b0);

    // Restart mid-operation: only the second request completes.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 16'h0009;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    run('h0019, 1'b1);

    // Start issued in the done cycle of the previous result.
    run('h0010, 1'b0);
    run('h0040, 1'b1);

    // Asynchronous reset while iterating.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rstx = 1'b0;
    #2 rstx = 1'b1;
    repeat (LAT + 5) @(negedge clk);

    for (int k = 0; k < BW_DIN; k++) run(1 << k, 1'b0);
    for (int k = 1; k <= BW_DIN; k++) run((1 << k) - 1, 1'b0);
    for (int n = 0; n < 250; n++) run(int'($urandom_range(0, (1 << BW_DIN) - 1)), 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
